// File: rtl/psg_frame_writer_if.sv
// Byte-stream input and PSG CPU-side bus of the frame writer.
// master is the writer's view; slave is the stream source / PSG side.
interface psg_frame_writer_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       bdir;
  logic       bc1;
  logic [7:0] psg_di;

  modport master (
    input  s_data,
    input  s_valid,
    output s_ready,
    output bdir,
    output bc1,
    output psg_di
  );

  modport slave (
    output s_data,
    output s_valid,
    input  s_ready,
    input  bdir,
    input  bc1,
    input  psg_di
  );
endinterface

// File: rtl/psg_frame_writer.sv
// PSG bus initiator: on each frame_tick writes NREGS stream bytes to R0 upwards,
// each as an address-latch phase followed by a register-write phase.
module psg_frame_writer #(
  parameter int unsigned NREGS       = 14,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter bit          SKIP_R13_FF = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frame_tick,
  psg_frame_writer_if.master bus,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_LATCH = 3'd2,
    ST_GAP1  = 3'd3,
    ST_WRITE = 3'd4,
    ST_GAP2  = 3'd5,
    ST_NEXT  = 3'd6
  } state_t;

  localparam logic [3:0] LAST_IDX   = 4'(NREGS - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] R13_IDX    = 4'd13;
  localparam logic [7:0] SKIP_VALUE = 8'hFF;

  state_t     state_r, state_s;
  logic [3:0] idx_r, idx_s;
  logic [3:0] hold_r, hold_s;
  logic [7:0] data_r, data_s;
  logic       skip_s;

  logic       bdir_r, bdir_s;
  logic       bc1_r, bc1_s;
  logic [7:0] psg_di_r, psg_di_s;
  logic       s_ready_r, s_ready_s;
  logic       busy_r, busy_s;
  logic       frame_done_r, frame_done_s;
  logic       overrun_r, overrun_s;

  // 0xFF for R13 would retrigger the envelope, so it is consumed silently
  assign skip_s = SKIP_R13_FF && (idx_r == R13_IDX) && (bus.s_data == SKIP_VALUE);

  // State, frame datapath and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      idx_r        <= 4'd0;
      hold_r       <= 4'd0;
      data_r       <= 8'h00;
      bdir_r       <= 1'b0;
      bc1_r        <= 1'b0;
      psg_di_r     <= 8'h00;
      s_ready_r    <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      hold_r       <= hold_s;
      data_r       <= data_s;
      bdir_r       <= bdir_s;
      bc1_r        <= bc1_s;
      psg_di_r     <= psg_di_s;
      s_ready_r    <= s_ready_s;
      busy_r       <= busy_s;
      frame_done_r <= frame_done_s;
      overrun_r    <= overrun_s;
    end
  end

  // Next-state: one WAIT/LATCH/GAP1/WRITE/GAP2/NEXT pass per register
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    hold_s  = hold_r;
    data_s  = data_r;
    case (state_r)
      ST_IDLE: begin
        if (frame_tick) begin
          state_s = ST_WAIT;
          idx_s   = 4'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (bus.s_valid) begin
          data_s = bus.s_data;
          hold_s = 4'd0;
          if (skip_s) begin
            state_s = ST_NEXT;
          end else begin
            state_s = ST_LATCH;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_LATCH: begin
        if (hold_r == HOLD_LAST) begin
          hold_s  = 4'd0;
          state_s = ST_GAP1;
        end else begin
          hold_s = hold_r + 4'd1;
        end
      end
      ST_GAP1: begin
        hold_s  = 4'd0;
        state_s = ST_WRITE;
      end
      ST_WRITE: begin
        if (hold_r == HOLD_LAST) begin
          hold_s  = 4'd0;
          state_s = ST_GAP2;
        end else begin
          hold_s = hold_r + 4'd1;
        end
      end
      ST_GAP2: begin
        state_s = ST_NEXT;
      end
      ST_NEXT: begin
        if (idx_r == LAST_IDX) begin
          state_s = ST_IDLE;
        end else begin
          idx_s   = idx_r + 4'd1;
          state_s = ST_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
        idx_s   = 4'd0;
        hold_s  = 4'd0;
      end
    endcase
  end

  // Outputs decoded from the upcoming state so the registers line up with it
  always_comb begin
    bdir_s       = 1'b0;
    bc1_s        = 1'b0;
    psg_di_s     = psg_di_r;
    s_ready_s    = 1'b0;
    busy_s       = (state_s != ST_IDLE);
    frame_done_s = (state_s == ST_NEXT) && (idx_s == LAST_IDX);
    overrun_s    = frame_tick && (state_r != ST_IDLE);
    case (state_s)
      ST_WAIT: begin
        s_ready_s = 1'b1;
      end
      ST_LATCH: begin
        bdir_s   = 1'b1;
        bc1_s    = 1'b1;
        psg_di_s = {4'h0, idx_s};
      end
      ST_GAP1: begin
        psg_di_s = {4'h0, idx_s};
      end
      ST_WRITE: begin
        bdir_s   = 1'b1;
        psg_di_s = data_s;
      end
      default: begin
        psg_di_s = psg_di_r;
      end
    endcase
  end

  assign bus.bdir    = bdir_r;
  assign bus.bc1     = bc1_r;
  assign bus.psg_di  = psg_di_r;
  assign bus.s_ready = s_ready_r;
  assign busy        = busy_r;
  assign frame_done  = frame_done_r;
  assign overrun     = overrun_r;

endmodule

// File: tb/tb_psg_frame_writer.sv
// Bench for psg_frame_writer: a timeline model of the frame protocol checked every
// cycle, plus literal expectations for latency, write lists and a small instance.
module tb_psg_frame_writer;

  localparam int A_NREGS = 14;
  localparam int A_H     = 2;
  localparam bit A_SKIP  = 1'b1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic tick_a = 1'b0;
  logic tick_b = 1'b0;
  logic a_busy, a_done, a_ovr;
  logic b_busy, b_done, b_ovr;

  psg_frame_writer_if bus_a ();
  psg_frame_writer_if bus_b ();

  psg_frame_writer #(.NREGS(A_NREGS), .HOLD_CYCLES(A_H), .SKIP_R13_FF(A_SKIP)) dut_a (
    .clock(clock), .reset(reset), .frame_tick(tick_a), .bus(bus_a.master),
    .busy(a_busy), .frame_done(a_done), .overrun(a_ovr)
  );

  psg_frame_writer #(.NREGS(3), .HOLD_CYCLES(1), .SKIP_R13_FF(1'b1)) dut_b (
    .clock(clock), .reset(reset), .frame_tick(tick_b), .bus(bus_b.master),
    .busy(b_busy), .frame_done(b_done), .overrun(b_ovr)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) cyc_n <= cyc_n + 1;

  // ---------------- behavioural model of instance A ----------------
  logic       e_bdir = 1'b0, e_bc1 = 1'b0, e_ready = 1'b0, e_busy = 1'b0;
  logic       e_done = 1'b0, e_ovr = 1'b0;
  logic [7:0] e_di = 8'h00;
  logic       m_sv, m_st, m_active = 1'b0;
  logic [7:0] m_sd;

  task automatic m_edge(output bit ab);
    @(posedge clock);
    m_sv = bus_a.s_valid;
    m_sd = bus_a.s_data;
    m_st = tick_a;
    if (reset) begin
      e_bdir = 1'b0; e_bc1 = 1'b0; e_di = 8'h00; e_ready = 1'b0;
      e_busy = 1'b0; e_done = 1'b0; e_ovr = 1'b0; m_active = 1'b0;
      ab = 1'b1;
    end else begin
      e_ovr = m_st && m_active;
      ab = 1'b0;
    end
  endtask

  task automatic m_frame();
    bit ab;
    logic [7:0] b;
    m_active = 1'b1;
    for (int r = 0; r < A_NREGS; r++) begin
      e_bdir = 1'b0; e_bc1 = 1'b0; e_ready = 1'b1; e_busy = 1'b1; e_done = 1'b0;
      do begin
        m_edge(ab);
        if (ab) return;
      end while (!m_sv);
      b = m_sd;
      e_ready = 1'b0;
      if (!(A_SKIP && r == 13 && b == 8'hFF)) begin
        for (int h = 0; h < A_H; h++) begin
          if (h > 0) begin m_edge(ab); if (ab) return; end
          e_bdir = 1'b1; e_bc1 = 1'b1; e_di = 8'(r);
        end
        m_edge(ab); if (ab) return;
        e_bdir = 1'b0; e_bc1 = 1'b0;
        for (int h = 0; h < A_H; h++) begin
          m_edge(ab); if (ab) return;
          e_bdir = 1'b1; e_bc1 = 1'b0; e_di = b;
        end
        m_edge(ab); if (ab) return;
        e_bdir = 1'b0;
        m_edge(ab); if (ab) return;
      end
      e_done = (r == A_NREGS - 1);
      m_edge(ab); if (ab) return;
    end
    e_done = 1'b0; e_busy = 1'b0; e_ready = 1'b0; m_active = 1'b0;
  endtask

  initial begin : model
    bit ab;
    forever begin
      m_edge(ab);
      if (!ab && m_st) m_frame();
    end
  end

  // Cycle-by-cycle compare of instance A against the model
  always @(negedge clock) begin
    if (chk_en) begin
      chk("bdir", 32'(bus_a.bdir), 32'(e_bdir));
      chk("bc1", 32'(bus_a.bc1), 32'(e_bc1));
      chk("psg_di", 32'(bus_a.psg_di), 32'(e_di));
      chk("s_ready", 32'(bus_a.s_ready), 32'(e_ready));
      chk("busy", 32'(a_busy), 32'(e_busy));
      chk("frame_done", 32'(a_done), 32'(e_done));
      chk("overrun", 32'(a_ovr), 32'(e_ovr));
    end
  end

  // Bus monitor: collects (register, value) writes and pulse counts
  logic [11:0] obs_q[$];
  logic [3:0]  last_reg = 4'd0;
  logic [1:0]  prev_ph = 2'b00;
  int          done_cnt = 0, ovr_cnt = 0, done_at = 0;

  always @(negedge clock) begin
    if ({bus_a.bdir, bus_a.bc1} == 2'b11) last_reg = bus_a.psg_di[3:0];
    if ({bus_a.bdir, bus_a.bc1} == 2'b10 && prev_ph != 2'b10) obs_q.push_back({last_reg, bus_a.psg_di});
    prev_ph = {bus_a.bdir, bus_a.bc1};
    if (a_done === 1'b1) begin done_cnt++; done_at = cyc_n; end
    if (a_ovr === 1'b1) ovr_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [7:0] src_q[$];
  logic [7:0] fr [A_NREGS];
  int consumed = 0, gap_at = -1, gap_left = 0, stall_pct = 0, tick_at = 0;

  task automatic drive_src();
    bit en;
    if (gap_left > 0 && consumed == gap_at) begin
      en = 1'b0;
      gap_left--;
    end else begin
      en = ($urandom_range(99) >= stall_pct);
    end
    bus_a.s_valid = (src_q.size() > 0) && en;
    if (src_q.size() > 0) bus_a.s_data = src_q[0];
  endtask

  task automatic cyc();
    bit hs;
    hs = bus_a.s_valid && bus_a.s_ready;
    @(posedge clock);
    @(negedge clock);
    #1;
    if (hs) begin
      void'(src_q.pop_front());
      consumed++;
    end
    tick_a = 1'b0;
    tick_b = 1'b0;
    drive_src();
  endtask

  task automatic run_frame(input int stall, input int extra_at, input int exp_lat, input string tag);
    int base, d0, o0, k;
    logic [11:0] exp_q[$];
    base = obs_q.size(); d0 = done_cnt; o0 = ovr_cnt;
    for (int r = 0; r < A_NREGS; r++) begin
      src_q.push_back(fr[r]);
      if (!(r == 13 && fr[r] == 8'hFF)) exp_q.push_back({4'(r), fr[r]});
    end
    stall_pct = stall;
    drive_src();
    tick_a = 1'b1;
    tick_at = cyc_n;
    k = 0;
    while (done_cnt == d0 && k < 3000) begin
      cyc();
      k++;
      if (cyc_n - tick_at == extra_at) tick_a = 1'b1;
    end
    chk({tag, "_timeout"}, 32'(k < 3000), 32'd1);
    for (int i = 0; i < 4; i++) cyc();
    if (exp_lat > 0) chk({tag, "_latency"}, 32'(done_at - tick_at), 32'(exp_lat));
    chk({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_overrun_count"}, 32'(ovr_cnt - o0), (extra_at >= 0) ? 32'd1 : 32'd0);
    chk({tag, "_write_count"}, 32'(obs_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < obs_q.size()) chk({tag, "_write"}, 32'(obs_q[base + i]), 32'(exp_q[i]));
    end
    chk({tag, "_bytes_left"}, 32'(src_q.size()), 32'd0);
  endtask

  initial begin : stim
    int k, b_cnt, p, r;
    bit hsb;
    logic [1:0] pat [6];
    bus_a.s_valid = 1'b0; bus_a.s_data = 8'h00;
    bus_b.s_valid = 1'b0; bus_b.s_data = 8'hA0;
    reset = 1'b1;
    cyc();
    chk_en = 1'b1;
    cyc(); cyc();
    chk("rst_bus_a", 32'({bus_a.bdir, bus_a.bc1}), 32'd0);
    chk("rst_di_a", 32'(bus_a.psg_di), 32'h00);
    chk("rst_ready_a", 32'(bus_a.s_ready), 32'd0);
    chk("rst_flags_a", 32'({a_busy, a_done, a_ovr}), 32'd0);
    chk("rst_bus_b", 32'({bus_b.bdir, bus_b.bc1, b_busy}), 32'd0);
    reset = 1'b0;
    cyc(); cyc();

    // 1: 0x10..0x1D always valid
    for (int i = 0; i < A_NREGS; i++) fr[i] = 8'h10 + 8'(i);
    run_frame(0, -1, 112, "t1");
    // 2: byte 13 = 0xFF, extra tick coinciding with frame_done
    fr[13] = 8'hFF;
    run_frame(0, 106, 106, "t2");
    // 3: 20-cycle valid gap before byte 5
    for (int i = 0; i < A_NREGS; i++) fr[i] = 8'h30 + 8'(i);
    gap_at = consumed + 5; gap_left = 20;
    run_frame(0, -1, 0, "t3");
    // 4: second tick 10 cycles into the frame
    for (int i = 0; i < A_NREGS; i++) fr[i] = 8'h50 + 8'(i);
    run_frame(0, 10, 112, "t4");

    // 5: reset during WRITE of R7
    for (int i = 0; i < A_NREGS; i++) src_q.push_back(8'h70 + 8'(i));
    stall_pct = 0;
    drive_src();
    tick_a = 1'b1;
    cyc();
    k = 0;
    while (!(bus_a.bdir && !bus_a.bc1 && last_reg == 4'd7) && k < 2000) begin
      cyc();
      k++;
    end
    chk("t5_reach_w7", 32'(k < 2000), 32'd1);
    reset = 1'b1;
    cyc();
    chk("t5_bus_after_rst", 32'({bus_a.bdir, bus_a.bc1}), 32'd0);
    chk("t5_busy_after_rst", 32'(a_busy), 32'd0);
    reset = 1'b0;
    src_q.delete();
    drive_src();
    cyc(); cyc();
    for (int i = 0; i < A_NREGS; i++) fr[i] = 8'h90 + 8'(i);
    run_frame(0, -1, 112, "t5_restart");

    // Randomized frames with stalls, occasional R13=0xFF and stray ticks
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < A_NREGS; i++) fr[i] = 8'($urandom_range(255));
      if (f % 2 == 0) fr[13] = 8'hFF;
      run_frame(int'($urandom_range(40)), (f == 1) ? 3 + int'($urandom_range(50)) : -1, 0, "rand");
    end
    stall_pct = 0;

    // 6: NREGS=3, HOLD_CYCLES=1 instance, literal phase pattern
    pat[0] = 2'b00; pat[1] = 2'b11; pat[2] = 2'b00;
    pat[3] = 2'b10; pat[4] = 2'b00; pat[5] = 2'b00;
    b_cnt = 0;
    bus_b.s_valid = 1'b1;
    bus_b.s_data = 8'hA0;
    tick_b = 1'b1;
    for (int kk = 1; kk <= 19; kk++) begin
      hsb = bus_b.s_valid && bus_b.s_ready;
      cyc();
      if (hsb) b_cnt++;
      bus_b.s_data = 8'hA0 + 8'(b_cnt);
      p = (kk - 1) % 6;
      r = (kk - 1) / 6;
      chk("t6_phase", 32'({bus_b.bdir, bus_b.bc1}), (kk > 18) ? 32'd0 : 32'(pat[p]));
      if (kk <= 18 && (p == 1 || p == 2)) chk("t6_addr", 32'(bus_b.psg_di), 32'(r));
      if (kk <= 18 && p == 3) chk("t6_data", 32'(bus_b.psg_di), 32'hA0 + 32'(r));
      chk("t6_done", 32'(b_done), 32'(kk == 18));
      chk("t6_busy", 32'(b_busy), 32'(kk <= 18));
    end
    chk("t6_bytes", 32'(b_cnt), 32'd3);
    bus_b.s_valid = 1'b0;
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
